// File: rtl/fx2_fifo_arbiter_if.sv
// fx2_fifo_arbiter_if: two 32-bit sample streams plus the FX2 slave-FIFO write-port pins
interface fx2_fifo_arbiter_if;
  logic [31:0] s0_data;
  logic [31:0] s1_data;
  logic s0_valid;
  logic s0_ready;
  logic s1_valid;
  logic s1_ready;
  logic full_n;
  logic [7:0] fd;
  logic slwr_n;
  logic pktend_n;
  logic [1:0] fifoadr;
  logic grant;
  modport master(
    output s0_data, s0_valid, s1_data, s1_valid, full_n,
    input s0_ready, s1_ready, fd, slwr_n, pktend_n, fifoadr, grant
  );
  modport slave(
    input s0_data, s0_valid, s1_data, s1_valid, full_n,
    output s0_ready, s1_ready, fd, slwr_n, pktend_n, fifoadr, grant
  );
endinterface

// File: rtl/fx2_fifo_arbiter.sv
// fx2_fifo_arbiter: packet-granular round-robin of two word streams onto the FX2 byte-wide slave FIFO
module fx2_fifo_arbiter #(
  parameter int PKT_WORDS = 128,
  parameter int TIMEOUT = 4800,
  parameter logic [1:0] EP0_ADDR = 2'b00,
  parameter logic [1:0] EP1_ADDR = 2'b10
) (
  input logic clk,
  input logic reset,
  fx2_fifo_arbiter_if.slave bus
);
  localparam int CW = $clog2(PKT_WORDS);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT, B0, B1, B2, B3, PKTEND} state_t;
  state_t state, nxt;
  logic last_grant, nxt_grant, valid, hs;
  logic [CW-1:0] word_cnt, nxt_cnt;
  logic [TW-1:0] timer, nxt_timer;
  logic [31:0] din;
  logic [23:0] word;
  assign valid = bus.grant ? bus.s1_valid : bus.s0_valid;
  assign din = bus.grant ? bus.s1_data : bus.s0_data;
  assign bus.s0_ready = state == WAIT && !bus.grant && bus.full_n;
  assign bus.s1_ready = state == WAIT && bus.grant && bus.full_n;
  assign hs = state == WAIT && valid && bus.full_n;
  // next state, grant choice, word count and stall timer
  always_comb begin
    nxt = state;
    nxt_grant = bus.grant;
    nxt_cnt = word_cnt;
    nxt_timer = timer;
    unique case (state)
      IDLE: if (bus.s0_valid || bus.s1_valid) begin
        nxt_grant = (bus.s0_valid && bus.s1_valid) ? !last_grant : bus.s1_valid;
        nxt = SETUP;
      end
      SETUP: nxt = WAIT;
      WAIT: if (hs) begin
        nxt_timer = '0;
        nxt = B0;
      end else if (word_cnt == '0) begin
        nxt = valid ? WAIT : IDLE;
      end else if (timer == TW'(TIMEOUT - 1)) begin
        nxt = PKTEND;
      end else begin
        nxt_timer = timer + 1'b1;
      end
      B0: nxt = B1;
      B1: nxt = B2;
      B2: nxt = B3;
      B3: begin
        nxt_cnt = word_cnt == CW'(PKT_WORDS - 1) ? '0 : word_cnt + 1'b1;
        nxt = word_cnt == CW'(PKT_WORDS - 1) ? IDLE : WAIT;
      end
      PKTEND: begin
        nxt_cnt = '0;
        nxt_timer = '0;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // state register; pin outputs are registered from the next state so byte 0 appears the cycle after the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      word_cnt <= '0;
      timer <= '0;
      bus.grant <= 1'b0;
      bus.fifoadr <= EP0_ADDR;
      bus.fd <= '0;
      bus.slwr_n <= 1'b1;
      bus.pktend_n <= 1'b1;
    end else begin
      state <= nxt;
      word_cnt <= nxt_cnt;
      timer <= nxt_timer;
      bus.grant <= nxt_grant;
      if (state == IDLE && nxt == SETUP) begin
        last_grant <= nxt_grant;
        bus.fifoadr <= nxt_grant ? EP1_ADDR : EP0_ADDR;
      end
      bus.slwr_n <= !(nxt == B0 || nxt == B1 || nxt == B2 || nxt == B3);
      bus.pktend_n <= nxt != PKTEND;
      bus.fd <= nxt == B0 ? din[7:0] : nxt == B1 ? word[7:0] : nxt == B2 ? word[15:8] :
                nxt == B3 ? word[23:16] : bus.fd;
    end
  end
  // upper three bytes held for B1..B3; byte 0 goes straight to the pins
  always_ff @(posedge clk) begin
    if (hs) word <= din[31:8];
  end
endmodule
